// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : mmcm_drp_reconfig
// Description : DRP initiator that retunes a running MMCME2_ADV. On start it
//               holds the MMCM in reset, walks a caller-supplied table of
//               (address, keep-mask, data) entries doing one read-modify-write
//               per entry, then releases reset and waits for LOCKED.
// Ports       : clk/rst_n          DRP clock, async active-low reset
//               start              one-cycle request (accepted only when idle)
//               busy/done/error    run status (done pulses, error sticky)
//               tbl_idx            table row being fetched
//               tbl_addr/mask/data table row contents (valid 1 cycle later)
//               drp_*              DRP master side towards the MMCM
//               mmcm_rst           MMCM RST, active high
//               mmcm_locked        MMCM LOCKED, asynchronous to clk
// Revision    : 1.0 - initial release
// ============================================================================
module mmcm_drp_reconfig #(
    parameter int NUM_ENTRIES  = 8,
    parameter int IDX_W        = 3,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [6:0]       tbl_addr,
    input  logic [15:0]      tbl_mask,
    input  logic [15:0]      tbl_data,
    output logic [6:0]       drp_daddr,
    output logic [15:0]      drp_di,
    input  logic [15:0]      drp_do,
    output logic             drp_den,
    output logic             drp_dwe,
    input  logic             drp_drdy,
    output logic             mmcm_rst,
    input  logic             mmcm_locked
);

    localparam int TMR_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] C_DRDY_TO     = TMR_W'(DRDY_TIMEOUT);
    localparam logic [TMR_W-1:0] C_LOCK_TO     = TMR_W'(LOCK_TIMEOUT);
    // LOCKED can still be high from before the reset pulse took effect;
    // the first few cycles after release are not trusted.
    localparam logic [TMR_W-1:0] C_LOCK_IGNORE = TMR_W'(4);
    localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_RD_REQ    = 4'd2;
    localparam logic [3:0] S_RD_WAIT   = 4'd3;
    localparam logic [3:0] S_WR_REQ    = 4'd4;
    localparam logic [3:0] S_WR_WAIT   = 4'd5;
    localparam logic [3:0] S_NEXT      = 4'd6;
    localparam logic [3:0] S_RELEASE   = 4'd7;
    localparam logic [3:0] S_WAIT_LOCK = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;

    logic [3:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [15:0]      r_mask;
    logic [15:0]      r_data;
    logic             r_lock_meta;
    logic             r_locked_s;

    logic [TMR_W-1:0] w_timer_inc;
    logic [15:0]      w_new;

    // Saturating increment: the timer never wraps back to zero.
    assign w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + 1'b1;
    assign w_new       = (drp_do & r_mask) | (r_data & ~r_mask);

    // Two-flop synchroniser for the asynchronous LOCKED input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_locked_s  <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_mask    <= '0;
            r_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            tbl_idx   <= '0;
            drp_daddr <= '0;
            drp_di    <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            mmcm_rst  <= 1'b0;
        end else begin
            // DEN and done are single-cycle strobes by construction.
            done    <= 1'b0;
            drp_den <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        tbl_idx  <= '0;
                        mmcm_rst <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Address goes straight to the DRP bus; DEN rises with
                    // it so the read strobe occupies the RD_REQ cycle.
                    drp_daddr <= tbl_addr;
                    r_mask    <= tbl_mask;
                    r_data    <= tbl_data;
                    drp_dwe   <= 1'b0;
                    drp_den   <= 1'b1;
                    r_state   <= S_RD_REQ;
                end

                S_RD_REQ: begin
                    r_timer <= '0;
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    // DRDY is checked first so it wins over a same-cycle timeout.
                    if (drp_drdy) begin
                        drp_di  <= w_new;
                        drp_dwe <= 1'b1;
                        drp_den <= 1'b1;
                        r_state <= S_WR_REQ;
                    end else if (r_timer == C_DRDY_TO) begin
                        mmcm_rst <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                S_WR_REQ: begin
                    drp_dwe <= 1'b0;
                    r_timer <= '0;
                    r_state <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        r_state <= S_NEXT;
                    end else if (r_timer == C_DRDY_TO) begin
                        mmcm_rst <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                S_NEXT: begin
                    if (tbl_idx == C_LAST_IDX) begin
                        mmcm_rst <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= S_RELEASE;
                    end else begin
                        tbl_idx <= tbl_idx + 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_RELEASE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_LOCK;
                end

                S_WAIT_LOCK: begin
                    if ((r_timer >= C_LOCK_IGNORE) && r_locked_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_timer == C_LOCK_TO) begin
                        mmcm_rst <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                S_ERR: begin
                    mmcm_rst <= 1'b0;
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmcm_drp_reconfig
// Description : Self-checking bench for mmcm_drp_reconfig. Provides a DRP
//               responder with a register file and programmable DRDY latency,
//               an MMCM LOCKED model, and a table-level reference model that
//               predicts every DRP write from the read-modify-write rule.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmcm_drp_reconfig;

    localparam int NE       = 2;
    localparam int IW       = 3;
    localparam int DRDY_TO  = 40;
    localparam int LOCK_TO  = 1000;
    localparam int LOCK_DLY = 20;
    localparam int MAXC     = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [IW-1:0] tbl_idx;
    logic [6:0]    tbl_addr;
    logic [15:0]   tbl_mask, tbl_data;
    logic [6:0]    drp_daddr;
    logic [15:0]   drp_di;
    logic [15:0]   drp_do = 16'h0;
    logic          drp_den, drp_dwe;
    logic          drp_drdy = 1'b0;
    logic          mmcm_rst;
    logic          mmcm_locked = 1'b0;

    mmcm_drp_reconfig #(
        .NUM_ENTRIES (NE),
        .IDX_W       (IW),
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_mask   (tbl_mask),
        .tbl_data   (tbl_data),
        .drp_daddr  (drp_daddr),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_drdy   (drp_drdy),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked)
    );

    always #5 clk = ~clk;

    // Caller table (combinational lookup)
    logic [6:0]  t_addr [8];
    logic [15:0] t_mask [8];
    logic [15:0] t_data [8];
    assign tbl_addr = t_addr[tbl_idx];
    assign tbl_mask = t_mask[tbl_idx];
    assign tbl_data = t_data[tbl_idx];

    // Model configuration, written only by the stimulus process
    int fixed_lat   = 3;
    bit rand_lat    = 1'b0;
    bit noresp      = 1'b0;
    bit lock_enable = 1'b1;
    bit lock_high   = 1'b0;
    bit fill_ones   = 1'b1;
    int fill_req    = 0;

    // Model state, written only by the model processes
    logic [15:0] mem [128];
    int          fill_done = 0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [6:0]  p_addr = 7'h0;
    bit          p_we = 1'b0;
    bit          prev_den = 1'b0;
    int          den_count = 0;
    int          overlap_cnt = 0;
    int          rstviol_cnt = 0;
    int          den_cyc = 0;
    logic [6:0]  wlog_a [$];
    logic [15:0] wlog_d [$];
    int          lk_cnt = 0;
    int          cyc = 0;
    bit          prev_rst = 1'b0;
    bit          prev_err = 1'b0;
    int          rst_fall_cyc = 0;
    int          err_rise_cyc = 0;
    int          done_cyc = 0;
    int          done_count = 0;

    // DRP responder: register file, DRDY after a programmable delay
    always @(posedge clk) begin
        drp_drdy <= 1'b0;
        if (fill_req != fill_done) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= fill_ones ? 16'hFFFF : 16'($urandom);
            fill_done <= fill_req;
        end
        if (pend) begin
            if (cnt == 0) begin
                drp_drdy <= 1'b1;
                if (!p_we) drp_do <= mem[p_addr];
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (drp_den) begin
            den_count <= den_count + 1;
            den_cyc   <= cyc;
            if (pend || prev_den) overlap_cnt <= overlap_cnt + 1;
            if (!mmcm_rst) rstviol_cnt <= rstviol_cnt + 1;
            if (drp_dwe) begin
                mem[drp_daddr] <= drp_di;
                wlog_a.push_back(drp_daddr);
                wlog_d.push_back(drp_di);
            end
            if (!noresp) begin
                pend   <= 1'b1;
                cnt    <= rand_lat ? int'($urandom_range(10, 0)) : fixed_lat;
                p_addr <= drp_daddr;
                p_we   <= drp_dwe;
            end
        end
        prev_den <= drp_den;
    end

    // LOCKED model: rises LOCK_DLY cycles after RST falls
    always @(posedge clk) begin
        if (lock_high) begin
            mmcm_locked <= 1'b1;
            lk_cnt      <= 0;
        end else if (mmcm_rst || !lock_enable) begin
            mmcm_locked <= 1'b0;
            lk_cnt      <= 0;
        end else if (lk_cnt >= LOCK_DLY - 1) begin
            mmcm_locked <= 1'b1;
        end else begin
            lk_cnt <= lk_cnt + 1;
        end
    end

    // Event timestamps
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_rst <= mmcm_rst;
        prev_err <= error;
        if (prev_rst && !mmcm_rst) rst_fall_cyc <= cyc;
        if (!prev_err && error) err_rise_cyc <= cyc;
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    int tests_run = 0;
    int failures  = 0;

    logic [15:0] ref_mem [128];
    logic [6:0]  exp_a [8];
    logic [15:0] exp_d [8];

    task automatic fill_mem(input bit ones);
        fill_ones = ones;
        fill_req  = fill_req + 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_basic_table();
        t_addr[0] = 7'h08; t_mask[0] = 16'h1000; t_data[0] = 16'h0145;
        t_addr[1] = 7'h14; t_mask[1] = 16'h0000; t_data[1] = 16'h1041;
    endtask

    // Reference: apply each entry's keep-mask/OR rule to a copy of the register file
    task automatic build_expect();
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
        for (int e = 0; e < NE; e++) begin
            ref_mem[t_addr[e]] = (ref_mem[t_addr[e]] & t_mask[e]) | (t_data[e] & ~t_mask[e]);
            exp_a[e] = t_addr[e];
            exp_d[e] = ref_mem[t_addr[e]];
        end
    endtask

    task automatic run(output bit got_done, output bit got_err, output bit hung);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        got_done = 1'b0; got_err = 1'b0; hung = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            if (done) begin got_done = 1'b1; hung = 1'b0; break; end
            if (error && !busy) begin got_err = 1'b1; hung = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, error, tbl_idx, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst} !== '0) begin
            failures++;
            $display("FAIL reset_in: outputs got %b required all zero",
                     {busy, done, error, tbl_idx, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, error, drp_den, mmcm_rst} !== 5'b0) begin
            failures++;
            $display("FAIL reset_out: status got %b required 00000", {busy, done, error, drp_den, mmcm_rst});
        end
    endtask

    task automatic test_basic();
        bit gd, ge, hg;
        int wb, db, dn, ob, rb;
        fill_mem(1'b1);
        set_basic_table();
        rand_lat = 1'b0; fixed_lat = 3; noresp = 1'b0; lock_enable = 1'b1; lock_high = 1'b0;
        wb = wlog_a.size(); db = den_count; dn = done_count; ob = overlap_cnt; rb = rstviol_cnt;
        run(gd, ge, hg);
        repeat (3) @(negedge clk);
        tests_run++;
        if (gd !== 1'b1) begin failures++; $display("FAIL basic_done: got %b required 1 (hung=%b)", gd, hg); end
        tests_run++;
        if (wlog_a.size() - wb !== 2) begin
            failures++; $display("FAIL basic_nwr: got %0d required 2", wlog_a.size() - wb);
        end else begin
            tests_run++;
            if ({wlog_a[wb], wlog_d[wb]} !== {7'h08, 16'h1145}) begin
                failures++; $display("FAIL basic_wr0: got %h/%h required 08/1145", wlog_a[wb], wlog_d[wb]);
            end
            tests_run++;
            if ({wlog_a[wb+1], wlog_d[wb+1]} !== {7'h14, 16'h1041}) begin
                failures++; $display("FAIL basic_wr1: got %h/%h required 14/1041", wlog_a[wb+1], wlog_d[wb+1]);
            end
        end
        tests_run++;
        if (done_count - dn !== 1) begin failures++; $display("FAIL basic_ndone: got %0d required 1", done_count - dn); end
        tests_run++;
        if (error !== 1'b0) begin failures++; $display("FAIL basic_err: got %b required 0", error); end
        tests_run++;
        if (den_count - db !== 4) begin failures++; $display("FAIL basic_nden: got %0d required 4", den_count - db); end
        tests_run++;
        if (overlap_cnt - ob + rstviol_cnt - rb !== 0) begin
            failures++; $display("FAIL basic_protocol: violations got %0d required 0", overlap_cnt - ob + rstviol_cnt - rb);
        end
    endtask

    task automatic test_random_latency();
        bit gd, ge, hg;
        int wb, ob, rb;
        rand_lat = 1'b1;
        for (int it = 0; it < 6; it++) begin
            fill_mem(1'b0);
            for (int e = 0; e < NE; e++) begin
                t_addr[e] = 7'($urandom_range(127, 0));
                t_mask[e] = 16'($urandom);
                t_data[e] = 16'($urandom);
            end
            if (it == 2) t_addr[1] = t_addr[0];
            build_expect();
            wb = wlog_a.size(); ob = overlap_cnt; rb = rstviol_cnt;
            run(gd, ge, hg);
            repeat (2) @(negedge clk);
            tests_run++;
            if (gd !== 1'b1 || wlog_a.size() - wb !== NE) begin
                failures++;
                $display("FAIL rand_run%0d: done=%b writes=%0d required done=1 writes=%0d", it, gd, wlog_a.size() - wb, NE);
            end else begin
                for (int e = 0; e < NE; e++) begin
                    tests_run++;
                    if ({wlog_a[wb+e], wlog_d[wb+e]} !== {exp_a[e], exp_d[e]}) begin
                        failures++;
                        $display("FAIL rand_wr%0d_%0d: got %h/%h required %h/%h", it, e,
                                 wlog_a[wb+e], wlog_d[wb+e], exp_a[e], exp_d[e]);
                    end
                end
            end
            tests_run++;
            if (overlap_cnt - ob + rstviol_cnt - rb !== 0) begin
                failures++; $display("FAIL rand_protocol%0d: violations got %0d required 0", it, overlap_cnt - ob + rstviol_cnt - rb);
            end
        end
        rand_lat = 1'b0;
    endtask

    task automatic test_drdy_timeout();
        bit gd, ge, hg;
        int wb;
        fill_mem(1'b1);
        set_basic_table();
        noresp = 1'b1;
        wb = wlog_a.size();
        run(gd, ge, hg);
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ge, error, busy, mmcm_rst} !== 4'b1100) begin
            failures++; $display("FAIL drdy_to_state: err_seen/error/busy/rst got %b required 1100", {ge, error, busy, mmcm_rst});
        end
        tests_run++;
        if (wlog_a.size() - wb !== 0) begin failures++; $display("FAIL drdy_to_nwr: got %0d required 0", wlog_a.size() - wb); end
        // Read DEN cycle, DRDY_TO+1 wait cycles, then error visible
        tests_run++;
        if (err_rise_cyc - den_cyc !== DRDY_TO + 2) begin
            failures++; $display("FAIL drdy_to_time: got %0d required %0d", err_rise_cyc - den_cyc, DRDY_TO + 2);
        end
        noresp = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lock_timeout();
        bit gd, ge, hg;
        int dn;
        fill_mem(1'b1);
        set_basic_table();
        fixed_lat = 1; lock_enable = 1'b0;
        run(gd, ge, hg);
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ge, error, busy, mmcm_rst} !== 4'b1100) begin
            failures++; $display("FAIL lock_to_state: err_seen/error/busy/rst got %b required 1100", {ge, error, busy, mmcm_rst});
        end
        // RELEASE cycle, LOCK_TO+1 WAIT_LOCK cycles, then error visible
        tests_run++;
        if (err_rise_cyc - rst_fall_cyc !== LOCK_TO + 2) begin
            failures++; $display("FAIL lock_to_time: got %0d required %0d", err_rise_cyc - rst_fall_cyc, LOCK_TO + 2);
        end
        lock_enable = 1'b1;
        dn = done_count;
        run(gd, ge, hg);
        tests_run++;
        if ({gd, error} !== 2'b10) begin
            failures++; $display("FAIL lock_retry: done/error got %b required 10", {gd, error});
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_count - dn !== 1) begin failures++; $display("FAIL lock_retry_ndone: got %0d required 1", done_count - dn); end
    endtask

    task automatic test_back_to_back();
        int dn, wb, n;
        bit seen;
        fill_mem(1'b1);
        set_basic_table();
        fixed_lat = 2; lock_high = 1'b1;
        dn = done_count; wb = wlog_a.size(); seen = 1'b0; n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < MAXC && !seen; i++) begin
            if (done) seen = 1'b1;
            start = (n == 3 || n == 10 || n == 20) ? 1'b1 : 1'b0;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (done_count - dn !== 1 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_runs: done pulses got %0d busy %b required 1 and 0", done_count - dn, busy);
        end
        tests_run++;
        if (wlog_a.size() - wb !== 2) begin failures++; $display("FAIL b2b_nwr: got %0d required 2", wlog_a.size() - wb); end
        // RELEASE + 4 ignored WAIT_LOCK cycles + accepting cycle, done next
        tests_run++;
        if (done_cyc - rst_fall_cyc !== 6) begin
            failures++; $display("FAIL b2b_lock_ignore: done after %0d cycles required 6", done_cyc - rst_fall_cyc);
        end
        lock_high = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit gd, ge, hg;
        int wr_seen, wb;
        bit hit;
        fill_mem(1'b1);
        set_basic_table();
        fixed_lat = 5;
        wr_seen = 0; hit = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < MAXC && !hit; i++) begin
            if (drp_den && drp_dwe) begin
                wr_seen++;
                if (wr_seen == 2) hit = 1'b1;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!hit) begin failures++; $display("FAIL arst_reach: second write seen %b required 1", hit); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, error, tbl_idx, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst} !== '0) begin
            failures++;
            $display("FAIL arst_outputs: got %b required all zero",
                     {busy, done, error, tbl_idx, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        t_mask[0] = 16'h00FF; t_data[0] = 16'hA5C3;
        build_expect();
        wb = wlog_a.size();
        run(gd, ge, hg);
        repeat (2) @(negedge clk);
        tests_run++;
        if (gd !== 1'b1 || wlog_a.size() - wb !== NE) begin
            failures++; $display("FAIL arst_rerun: done=%b writes=%0d required 1 and %0d", gd, wlog_a.size() - wb, NE);
        end else begin
            for (int e = 0; e < NE; e++) begin
                tests_run++;
                if ({wlog_a[wb+e], wlog_d[wb+e]} !== {exp_a[e], exp_d[e]}) begin
                    failures++;
                    $display("FAIL arst_wr%0d: got %h/%h required %h/%h", e, wlog_a[wb+e], wlog_d[wb+e], exp_a[e], exp_d[e]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            t_addr[i] = 7'h0; t_mask[i] = 16'h0; t_data[i] = 16'h0;
        end
        test_reset();
        test_basic();
        test_random_latency();
        test_drdy_timeout();
        test_lock_timeout();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
`default_nettype wire
